// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared states and line-level constants for the FIFO-draining UART transmitter
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic UART_IDLE_LEVEL      = 1'b1;
   localparam logic START_BIT_LEVEL      = 1'b0;
   localparam logic STOP_BIT_LEVEL       = 1'b1;
   localparam int   DEFAULT_CLKS_PER_BIT = 868;
   localparam int   DEFAULT_WIDTH        = 8;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - read-side handshake between the TX FIFO and its UART drain
interface fifo_uart_tx_if #(
   parameter int c_WIDTH = fifo_uart_pkg::DEFAULT_WIDTH
) ();

   logic               fifo_empty;
   logic [c_WIDTH-1:0] fifo_data;
   logic               fifo_rden;

   // master is the reader that pops; slave is the FIFO itself
   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_rden
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_rden
   );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-time counter with clear and a one-cycle bit_end strobe
module uart_baud_gen #(
   parameter int c_CLKS_PER_BIT = fifo_uart_pkg::DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bit_end
);

   localparam int            CW   = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(c_CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   // clear forces count to 0, and LAST is at least 1, so no strobe while cleared
   assign bit_end = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops the TX FIFO one word at a time and sends it as a UART frame; UART_TX_PARITY_EN adds an even parity bit
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int c_WIDTH        = DEFAULT_WIDTH,
   parameter int c_CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   fifo_uart_tx_if.master        fifo,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int            IW       = (c_WIDTH > 1) ? $clog2(c_WIDTH) : 1;
   localparam logic [IW-1:0] LAST_BIT = IW'(c_WIDTH - 1);

   tx_state_t          state_q, state_d;
   logic [c_WIDTH-1:0] shift_q, shift_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic               tx_d, rden_q, rden_d, done_d;
   logic               baud_clear, bit_end;
`ifdef UART_TX_PARITY_EN
   logic               parity_q, parity_d;
`endif

   // The bit timer only runs while a frame is on the wire
   assign baud_clear = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);

   uart_baud_gen #(
      .c_CLKS_PER_BIT(c_CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .clear  (baud_clear),
      .bit_end(bit_end)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      tx_d    = tx;
      rden_d  = 1'b0;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (enable && !fifo.fifo_empty) begin
               rden_d  = 1'b1;
               state_d = POP;
            end
         end
         POP: state_d = LOAD;
         LOAD: begin
            shift_d = fifo.fifo_data;
            tx_d    = START_BIT_LEVEL;
            idx_d   = '0;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo.fifo_data;
`endif
         end
         START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = PARITY;
`else
                  tx_d    = STOP_BIT_LEVEL;
                  state_d = STOP;
`endif
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_d[0];
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               tx_d    = STOP_BIT_LEVEL;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            tx_d    = UART_IDLE_LEVEL;
            state_d = IDLE;
         end
      endcase
   end

   // Reset mid-frame simply abandons the popped word; the FIFO is not rewound
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx      <= UART_IDLE_LEVEL;
         rden_q  <= 1'b0;
         tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx      <= tx_d;
         rden_q  <= rden_d;
         tx_done <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign fifo.fifo_rden = rden_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx with a behavioural FIFO and frame model
module tb_fifo_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NSLOTS = 10 + PAR;
   localparam int TMO    = 200;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
      logic       par;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   logic tx, busy, tx_done;

   fifo_uart_tx_if #(.c_WIDTH(8)) fif ();

   fifo_uart_tx #(
      .c_WIDTH       (8),
      .c_CLKS_PER_BIT(CPB)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .fifo   (fif),
      .tx     (tx),
      .busy   (busy),
      .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   logic [7:0] fq[$];
   int         underflow_cnt = 0;

   // Registered FIFO: data_out valid after the edge that sampled rden
   always @(posedge clk) begin
      if (fif.fifo_rden === 1'b1) begin
         if (fq.size() > 0) fif.fifo_data <= fq.pop_front();
         else underflow_cnt++;
      end
      fif.fifo_empty <= (fq.size() == 0);
   end

   int rden_cnt = 0, rden_run = 0, rden_max = 0;
   always @(negedge clk) begin
      if (fif.fifo_rden === 1'b1) begin
         rden_cnt++;
         rden_run++;
         if (rden_run > rden_max) rden_max = rden_run;
      end else begin
         rden_run = 0;
      end
   end

   int pass_cnt = 0, total_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [7:0] b);
      fq.push_back(b);
   endtask

   function automatic logic [10:0] model_slots(input logic [7:0] d);
      logic [10:0] s;
      int ones;
      s = '0;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         s[i+1] = d[i];
         ones += int'(d[i]);
      end
      if (PAR != 0) begin
         s[9]  = ((ones % 2) != 0);
         s[10] = 1'b1;
      end else begin
         s[9] = 1'b1;
      end
      return s;
   endfunction

   function automatic logic [10:0] tbl_slots(input vec_t v);
      if (PAR != 0) return {1'b1, v.par, v.frame[8:0]};
      return {1'b0, v.frame};
   endfunction

   function automatic logic [47:0] expand(input logic [10:0] s);
      logic [47:0] w;
      w = '0;
      for (int k = 0; k < NSLOTS * CPB; k++) w[k] = s[k / CPB];
      return w;
   endfunction

   // Starts at a negedge; ends on the negedge where tx_done should be seen
   task automatic expect_frame(input logic [10:0] slots, input string name,
                               input int drop_at, input int exp_gap);
      int          waited;
      logic [47:0] obs;
      bit          busy_ok, early_done;
      waited = 0;
      while (tx !== 1'b0 && waited < TMO) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= TMO) begin
         check({name, "_start_timeout"}, 1, 0);
         return;
      end
      if (exp_gap >= 0) check({name, "_idle_gap"}, waited, exp_gap);
      obs = '0;
      busy_ok = 1'b1;
      early_done = 1'b0;
      for (int k = 0; k < NSLOTS * CPB; k++) begin
         obs[k] = tx;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (tx_done !== 1'b0) early_done = 1'b1;
         if (k == drop_at) enable = 1'b0;
         @(negedge clk);
      end
      check({name, "_bits"}, obs, expand(slots));
      check({name, "_busy"}, busy_ok, 1'b1);
      check({name, "_no_early_done"}, early_done, 1'b0);
      check({name, "_done_tx"}, {tx_done, tx}, 2'b11);
   endtask

   vec_t       tbl[6];
   logic [7:0] burst[$];
   int         exp_pops;
   int         w, lows, dones;

   initial begin
      tbl[0] = '{8'hA5, 10'b1_1010_0101_0, 1'b0};
      tbl[1] = '{8'h00, 10'b1_0000_0000_0, 1'b0};
      tbl[2] = '{8'hFF, 10'b1_1111_1111_0, 1'b0};
      tbl[3] = '{8'h55, 10'b1_0101_0101_0, 1'b0};
      tbl[4] = '{8'h07, 10'b1_0000_0111_0, 1'b1};
      tbl[5] = '{8'h03, 10'b1_0000_0011_0, 1'b0};

      reset  = 1'b1;
      enable = 1'b1;
      push(tbl[0].data);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("reset_hold", {tx, fif.fifo_rden, busy, tx_done}, 4'b1000);
         @(negedge clk);
      end
      enable = 1'b0;
      reset  = 1'b0;
      repeat (8) @(negedge clk);
      check("enable0_no_pop", rden_cnt, 0);
      check("enable0_idle", {tx, busy}, 2'b10);

      enable = 1'b1;
      expect_frame(tbl_slots(tbl[0]), "frame_a5", -1, 3);
      exp_pops = 1;
      check("pops_a5", rden_cnt, exp_pops);

      for (int i = 1; i < 6; i++) push(tbl[i].data);
      for (int i = 1; i < 6; i++) begin
         expect_frame(tbl_slots(tbl[i]), $sformatf("frame_tbl%0d", i), -1, (i == 1) ? -1 : 3);
         exp_pops++;
      end
      check("pops_tbl", rden_cnt, exp_pops);

      push(8'h3C);
      push(8'h96);
      expect_frame(model_slots(8'h3C), "frame_drop", 15, 4);
      exp_pops++;
      repeat (20) @(negedge clk);
      check("drop_no_pop", rden_cnt, exp_pops);
      check("drop_idle", {tx, busy}, 2'b10);

      // Abort during data bit 3 of 0x96
      enable = 1'b1;
      w = 0;
      while (tx !== 1'b0 && w < TMO) begin
         @(negedge clk);
         w++;
      end
      check("abort_start_seen", (w < TMO), 1'b1);
      exp_pops++;
      repeat (17) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_state", {tx, busy, fif.fifo_rden, tx_done}, 4'b1000);
      reset = 1'b0;
      lows = 0;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
         if (tx_done !== 1'b0) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_line_high", lows, 0);
      check("abort_pops", rden_cnt, exp_pops);

      push(8'h4B);
      expect_frame(model_slots(8'h4B), "frame_after_reset", -1, -1);
      exp_pops++;

      for (int b = 0; b < 4; b++) begin
         burst.delete();
         for (int j = 0; j < int'($urandom_range(1, 4)); j++) burst.push_back(8'($urandom));
         foreach (burst[j]) push(burst[j]);
         foreach (burst[j]) begin
            expect_frame(model_slots(burst[j]), $sformatf("rand_b%0d_f%0d", b, j), -1, (j == 0) ? -1 : 3);
            exp_pops++;
         end
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      check("total_pops", rden_cnt, exp_pops);
      check("rden_single_cycle", rden_max, 1);
      check("no_underflow", underflow_cnt, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule
